// File: rtl/riscv_multicycle_ctrl_if.sv
// Control/datapath/memory signal bundle for the multicycle RISC-V controller.
interface riscv_multicycle_ctrl_if;
    logic        iMemRead;
    logic [31:0] iReadData;
    logic        iValid;
    logic [31:0] instruction;
    logic        PCSrc;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemtoReg;
    logic [3:0]  ALUCtrl;
    logic        loadPC;
    logic        Zero;
    logic        dMemRead;
    logic        dMemWrite;
    logic        dAck;
    logic        illegal_instr;
    logic [2:0]  state_o;
    logic [31:0] instret;

    // Controller side
    modport master (
        output iMemRead, instruction, PCSrc, ALUSrc, RegWrite, MemtoReg,
               ALUCtrl, loadPC, dMemRead, dMemWrite, illegal_instr,
               state_o, instret,
        input  iReadData, iValid, Zero, dAck
    );

    // Datapath / memory side
    modport slave (
        input  iMemRead, instruction, PCSrc, ALUSrc, RegWrite, MemtoReg,
               ALUCtrl, loadPC, dMemRead, dMemWrite, illegal_instr,
               state_o, instret,
        output iReadData, iValid, Zero, dAck
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control FSM for the simple RISC-V datapath: fetch, decode,
// execute, memory and write-back sequencing with instruction register and
// retired-instruction counter.
module riscv_multicycle_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter logic [3:0]  ALUOP_ADD = 4'b0010
) (
    input  logic                    clk,
    input  logic                    rst,
    riscv_multicycle_ctrl_if.master bus
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        K_ALU = 2'd0,
        K_LW  = 2'd1,
        K_SW  = 2'd2,
        K_BEQ = 2'd3
    } kind_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic        r_illegal;
    logic [31:0] r_instret;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_legal;
    kind_t       w_kind;
    logic [3:0]  w_dec_alu_ctrl;
    logic        w_dec_alu_src;

    logic        w_imem_read;
    logic        w_load_ir;
    logic        w_pc_src;
    logic        w_alu_src;
    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic [3:0]  w_alu_ctrl;
    logic        w_load_pc;
    logic        w_dmem_read;
    logic        w_dmem_write;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_funct7 = r_ir[31:25];

    // funct3 to ALU op; alt selects SUB/SRA where the encoding allows it
    function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_op = alt ? ALU_SUB : ALUOP_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            default: f3_op = ALU_AND;
        endcase
    endfunction

    // Instruction decode from the instruction register
    always_comb begin
        w_legal        = 1'b0;
        w_kind         = K_ALU;
        w_dec_alu_ctrl = ALUOP_ADD;
        w_dec_alu_src  = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_dec_alu_ctrl = f3_op(w_funct3, w_funct7[5]);
                if (w_funct3 != 3'b011) begin
                    if (w_funct7 == F7_ZERO)
                        w_legal = 1'b1;
                    else if (w_funct7 == F7_ALT && (w_funct3 == 3'b000 || w_funct3 == 3'b101))
                        w_legal = 1'b1;
                end
            end
            OP_I: begin
                w_dec_alu_src  = 1'b1;
                w_dec_alu_ctrl = f3_op(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                case (w_funct3)
                    3'b011:  w_legal = 1'b0;
                    3'b001:  w_legal = (w_funct7 == F7_ZERO);
                    3'b101:  w_legal = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
                    default: w_legal = 1'b1;
                endcase
            end
            OP_LW: begin
                w_kind        = K_LW;
                w_dec_alu_src = 1'b1;
                w_legal       = (w_funct3 == 3'b010);
            end
            OP_SW: begin
                w_kind        = K_SW;
                w_dec_alu_src = 1'b1;
                w_legal       = (w_funct3 == 3'b010);
            end
            OP_BEQ: begin
                w_kind         = K_BEQ;
                w_dec_alu_ctrl = ALU_SUB;
                w_legal        = (w_funct3 == 3'b000);
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Next-state and control strobes; everything held low while in reset
    always_comb begin
        w_next       = r_state;
        w_imem_read  = 1'b0;
        w_load_ir    = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_ctrl   = 4'b0000;
        w_load_pc    = 1'b0;
        w_dmem_read  = 1'b0;
        w_dmem_write = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IF: begin
                    w_imem_read = 1'b1;
                    if (bus.iValid) begin
                        w_load_ir = 1'b1;
                        w_next    = S_ID;
                    end
                end
                S_ID: w_next = w_legal ? S_EX : S_ERR;
                S_EX: begin
                    w_alu_src  = w_dec_alu_src;
                    w_alu_ctrl = w_dec_alu_ctrl;
                    case (w_kind)
                        K_ALU:   w_next = S_WB;
                        K_BEQ: begin
                            w_load_pc = 1'b1;
                            w_pc_src  = bus.Zero;
                            w_next    = S_IF;
                        end
                        default: w_next = S_MEM;
                    endcase
                end
                S_MEM: begin
                    w_alu_src  = 1'b1;
                    w_alu_ctrl = ALUOP_ADD;
                    if (w_kind == K_LW) begin
                        w_dmem_read = 1'b1;
                        if (bus.dAck) w_next = S_WB;
                    end else begin
                        w_dmem_write = 1'b1;
                        if (bus.dAck) begin
                            w_load_pc = 1'b1;
                            w_next    = S_IF;
                        end
                    end
                end
                S_WB: begin
                    w_alu_src    = w_dec_alu_src;
                    w_alu_ctrl   = w_dec_alu_ctrl;
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = (w_kind == K_LW);
                    w_load_pc    = 1'b1;
                    w_next       = S_IF;
                end
                S_ERR:   w_next = S_ERR;
                default: w_next = S_IF;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IF;
        else     r_state <= w_next;
    end

    // Instruction register, sticky illegal flag and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir      <= NOP_INSTR;
            r_illegal <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            if (w_load_ir)         r_ir      <= bus.iReadData;
            if (w_next == S_ERR)   r_illegal <= 1'b1;
            if (w_load_pc)         r_instret <= r_instret + 32'd1;
        end
    end

    assign bus.iMemRead      = w_imem_read;
    assign bus.instruction   = r_ir;
    assign bus.PCSrc         = w_pc_src;
    assign bus.ALUSrc        = w_alu_src;
    assign bus.RegWrite      = w_reg_write;
    assign bus.MemtoReg      = w_mem_to_reg;
    assign bus.ALUCtrl       = w_alu_ctrl;
    assign bus.loadPC        = w_load_pc;
    assign bus.dMemRead      = w_dmem_read;
    assign bus.dMemWrite     = w_dmem_write;
    assign bus.illegal_instr = r_illegal;
    assign bus.state_o       = 3'(r_state);
    assign bus.instret       = r_instret;

endmodule
